// File: rtl/uart_rx_ext.sv
// UART receive engine: configurable width/parity/stop bits, glitch-rejecting start, valid/ready output.
// Outputs update on the final stop-sample edge; a frame arriving while valid && !ready is dropped and flagged as overrun.
module uart_rx_ext #(
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_TC  = CW'(CLOCKS_PER_PULSE/2 - 1);
  localparam logic [CW-1:0] FULL_TC  = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_nxt;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 stop_last;
  logic [DATA_BITS-1:0] shift;
  logic                 p_err;
  logic                 f_err;
  logic                 f_fin;
  logic                 armed;
  logic                 cnt_clr;
  logic                 data_smp;
  logic                 par_smp;
  logic                 stop_smp;
  logic                 commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  // The final stop sample must count toward the committed framing flag.
  assign f_fin = f_err | ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    data_smp  = 1'b0;
    par_smp   = 1'b0;
    stop_smp  = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s && armed) begin
          cnt_clr   = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (cnt == HALF_TC) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == FULL_TC) begin
          cnt_clr  = 1'b1;
          data_smp = 1'b1;
          if (bit_idx == LAST_IDX) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cnt == FULL_TC) begin
          cnt_clr   = 1'b1;
          par_smp   = 1'b1;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == FULL_TC) begin
          cnt_clr  = 1'b1;
          stop_smp = 1'b1;
          if (stop_last) begin
            commit    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      p_err    <= 1'b0;
      f_err    <= 1'b0;
    end else begin
      if (cnt_clr || state == S_IDLE) cnt <= '0;
      else                            cnt <= cnt + CW'(1);

      if (state == S_START) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        p_err    <= 1'b0;
        f_err    <= 1'b0;
      end

      if (data_smp) begin
        bit_idx <= bit_idx + IW'(1);
        for (int i = 0; i < DATA_BITS; i++)
          if (bit_idx == IW'(i)) shift[i] <= rx_s;
      end

      // XOR over data and parity bit is 1 when total ones are odd.
      if (par_smp) p_err <= (PARITY == 1) ? ~(^shift ^ rx_s) : (^shift ^ rx_s);

      if (stop_smp) begin
        stop_idx <= stop_idx + 1'b1;
        if (!rx_s) f_err <= 1'b1;
      end
    end
  end

  // A committed framing error disarms until the line goes high, so a break yields one frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          armed <= 1'b1;
    else if (commit && f_fin)         armed <= 1'b0;
    else if (state == S_IDLE && rx_s) armed <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit && (!valid || ready)) begin
      data_out   <= shift;
      parity_err <= p_err;
      frame_err  <= f_fin;
      valid      <= 1'b1;
      overrun    <= 1'b0;
    end else if (commit) begin
      overrun    <= 1'b1;
    end else if (valid && ready) begin
      valid      <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext: three configurations (8N1, 8E1, 7O2) driven from serial frame tasks.
module tb_uart_rx_ext;
  localparam int CPP = 16;

  typedef struct packed {
    logic       ovr;
    logic       ferr;
    logic       perr;
    logic [8:0] dat;
  } frm_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_l [3];
  logic       ready_n, ready_e, ready_o;
  logic [7:0] data_n, data_e;
  logic [6:0] data_o;
  logic       valid_n, valid_e, valid_o;
  logic       perr_n, perr_e, perr_o;
  logic       ferr_n, ferr_e, ferr_o;
  logic       ovr_n, ovr_e, ovr_o;

  int checks   = 0;
  int failures = 0;

  frm_t q_n[$], q_e[$], q_o[$];
  frm_t e_n, e_e, e_o;

  always #5 clk = ~clk;

  uart_rx_ext #(.CLOCKS_PER_PULSE(CPP), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n81 (
    .clk(clk), .rst(rst), .rx(rx_l[0]), .data_out(data_n), .valid(valid_n), .ready(ready_n),
    .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_n));

  uart_rx_ext #(.CLOCKS_PER_PULSE(CPP), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e81 (
    .clk(clk), .rst(rst), .rx(rx_l[1]), .data_out(data_e), .valid(valid_e), .ready(ready_e),
    .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e));

  uart_rx_ext #(.CLOCKS_PER_PULSE(CPP), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_o72 (
    .clk(clk), .rst(rst), .rx(rx_l[2]), .data_out(data_o), .valid(valid_o), .ready(ready_o),
    .parity_err(perr_o), .frame_err(ferr_o), .overrun(ovr_o));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic frm_t mkf(input logic ovr, input logic ferr, input logic perr, input logic [8:0] dat);
    frm_t f;
    f.ovr  = ovr;
    f.ferr = ferr;
    f.perr = perr;
    f.dat  = dat;
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pmode: 0 none, 1 odd, 2 even; pflip inverts the correct parity bit.
  task automatic send(input int inst, input logic [8:0] dat, input int nbits, input int pmode,
                      input bit pflip, input int nstop, input bit stop_val);
    logic p;
    p = 1'b0;
    rx_l[inst] = 1'b0;
    tick(CPP);
    for (int i = 0; i < nbits; i++) begin
      p = p ^ dat[i];
      rx_l[inst] = dat[i];
      tick(CPP);
    end
    if (pmode != 0) begin
      rx_l[inst] = ((pmode == 1) ? ~p : p) ^ pflip;
      tick(CPP);
    end
    for (int i = 0; i < nstop; i++) begin
      rx_l[inst] = stop_val;
      tick(CPP);
    end
    rx_l[inst] = 1'b1;
  endtask

  // A transfer with nothing queued compares against an all-ones value no real frame can produce.
  always @(negedge clk) begin
    if (!rst && valid_n && ready_n) begin
      if (q_n.size() > 0) e_n = q_n.pop_front();
      else                e_n = '1;
      chk("n81_frame", {ovr_n, ferr_n, perr_n, 1'b0, data_n}, e_n);
    end
    if (!rst && valid_e && ready_e) begin
      if (q_e.size() > 0) e_e = q_e.pop_front();
      else                e_e = '1;
      chk("e81_frame", {ovr_e, ferr_e, perr_e, 1'b0, data_e}, e_e);
    end
    if (!rst && valid_o && ready_o) begin
      if (q_o.size() > 0) e_o = q_o.pop_front();
      else                e_o = '1;
      chk("o72_frame", {ovr_o, ferr_o, perr_o, 2'b00, data_o}, e_o);
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) rx_l[i] = 1'b1;
    ready_n = 1'b1;
    ready_e = 1'b1;
    ready_o = 1'b1;
    tick(3);
    chk("rst_n81", {valid_n, ovr_n, ferr_n, perr_n, data_n}, 0);
    chk("rst_e81", {valid_e, ovr_e, ferr_e, perr_e, data_e}, 0);
    chk("rst_o72", {valid_o, ovr_o, ferr_o, perr_o, data_o}, 0);
    rst = 1'b0;
    tick(20);

    // nominal 8N1 with ready held high
    q_n.push_back(mkf(1'b0, 1'b0, 1'b0, 9'h0A5));
    send(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
    tick(40);
    chk("n81_pulse_end", valid_n, 0);

    // even parity: correct, then flipped parity bit
    q_e.push_back(mkf(1'b0, 1'b0, 1'b0, 9'h03C));
    send(1, 9'h03C, 8, 2, 1'b0, 1, 1'b1);
    tick(40);
    q_e.push_back(mkf(1'b0, 1'b0, 1'b1, 9'h03C));
    send(1, 9'h03C, 8, 2, 1'b1, 1, 1'b1);
    tick(40);

    // framing error, then a 40-bit break yields exactly one more frame
    q_n.push_back(mkf(1'b0, 1'b1, 1'b0, 9'h055));
    send(0, 9'h055, 8, 0, 1'b0, 1, 1'b0);
    tick(32);
    q_n.push_back(mkf(1'b0, 1'b1, 1'b0, 9'h000));
    rx_l[0] = 1'b0;
    tick(40 * CPP);
    rx_l[0] = 1'b1;
    tick(40);

    // glitch shorter than half a bit is ignored
    rx_l[0] = 1'b0;
    tick(5);
    rx_l[0] = 1'b1;
    tick(40);
    q_n.push_back(mkf(1'b0, 1'b0, 1'b0, 9'h012));
    send(0, 9'h012, 8, 0, 1'b0, 1, 1'b1);
    tick(40);

    // overrun: second frame dropped while first is held
    ready_n = 1'b0;
    q_n.push_back(mkf(1'b1, 1'b0, 1'b0, 9'h011));
    send(0, 9'h011, 8, 0, 1'b0, 1, 1'b1);
    tick(20);
    send(0, 9'h022, 8, 0, 1'b0, 1, 1'b1);
    tick(20);
    chk("ovr_valid", valid_n, 1);
    chk("ovr_data", data_n, 8'h11);
    chk("ovr_flag", ovr_n, 1);
    ready_n = 1'b1;
    tick(1);
    ready_n = 1'b0;
    chk("ovr_clr_valid", valid_n, 0);
    chk("ovr_clr_flag", ovr_n, 0);
    chk("ovr_data_hold", data_n, 8'h11);

    // ready pulsed exactly on the commit edge of the second frame
    q_n.push_back(mkf(1'b0, 1'b0, 1'b0, 9'h011));
    send(0, 9'h011, 8, 0, 1'b0, 1, 1'b1);
    tick(20);
    q_n.push_back(mkf(1'b0, 1'b0, 1'b0, 9'h022));
    fork
      send(0, 9'h022, 8, 0, 1'b0, 1, 1'b1);
      begin
        // start fall +2 sync +1 idle, half bit start, 9 full bits to the stop sample
        tick(2 + CPP/2 + 9*CPP);
        ready_n = 1'b1;
        tick(1);
        ready_n = 1'b0;
      end
    join
    tick(20);
    chk("sim_valid", valid_n, 1);
    chk("sim_data", data_n, 8'h22);
    chk("sim_ovr", ovr_n, 0);
    ready_n = 1'b1;
    tick(5);

    // 7 data bits, odd parity, 2 stop bits
    q_o.push_back(mkf(1'b0, 1'b0, 1'b0, 9'h05A));
    send(2, 9'h05A, 7, 1, 1'b0, 2, 1'b1);
    tick(40);

    // reset in the middle of a data bit while a frame is held
    ready_o = 1'b0;
    send(2, 9'h00F, 7, 1, 1'b0, 2, 1'b1);
    tick(20);
    chk("o72_held", {valid_o, data_o}, {1'b1, 7'h0F});
    rx_l[2] = 1'b0;
    tick(CPP);
    rx_l[2] = 1'b1;
    tick(CPP);
    rx_l[2] = 1'b0;
    tick(CPP/2);
    rst = 1'b1;
    rx_l[2] = 1'b1;
    #1;
    chk("rst_mid", {valid_o, ovr_o, ferr_o, perr_o, data_o}, 0);
    tick(3);
    rst = 1'b0;
    tick(30);
    ready_o = 1'b1;
    q_o.push_back(mkf(1'b0, 1'b0, 1'b0, 9'h033));
    send(2, 9'h033, 7, 1, 1'b0, 2, 1'b1);
    tick(40);

    chk("n81_drain", q_n.size(), 0);
    chk("e81_drain", q_e.size(), 0);
    chk("o72_drain", q_o.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receive engine for the FPGA UART datapath, sitting between the raw `rx` pin and the byte-consuming logic. It extends the current fixed 8N1 receiver with:
- configurable data width, parity mode and stop-bit count;
- start-bit glitch rejection;
- parity and framing error detection;
- a valid/ready output handshake with overrun detection.

## Interface
- `CLOCKS_PER_PULSE`, 5208: clock cycles per bit period; must be ≥ 4.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9, received LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, asynchronous to `clk`; idles high.
- `data_out`  out  DATA_BITS  received word, held stable while `valid` = 1.
- `valid`  out  1  `data_out` and the flags hold an unconsumed frame.
- `ready`  in  1  consumer accepts; a transfer occurs when `valid` & `ready`.
- `parity_err`  out  1  parity mismatch on the held frame; always 0 when `PARITY` = 0.
- `frame_err`  out  1  a stop bit on the held frame sampled 0.
- `overrun`  out  1  at least one later frame was dropped while the held frame was pending.

## Operation
- **Input sync:** `rx` passes through a 2-flop synchroniser to produce `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- **Counters:**
  - Bit-period counter of width `$clog2(CLOCKS_PER_PULSE)`.
  - Bit index counter of width `$clog2(DATA_BITS)`.
- **State machine:**
  - **IDLE:** when `rx_s` = 0 and the receiver is armed, clear the counter and go to START.
  - **START:** count up to `CLOCKS_PER_PULSE/2-1`. At terminal count:
    - `rx_s` = 0: clear the counter and go to DATA.
    - `rx_s` = 1 (glitch): return to IDLE; nothing is flagged.
  - **DATA:** at each count of `CLOCKS_PER_PULSE-1`, write `rx_s` into shift bit [index]. After bit `DATA_BITS-1`, go to PARITY if `PARITY` ≠ 0, otherwise go to STOP.
  - **PARITY:** one bit period; sample at terminal count. Compute `p_err` against XOR of the data bits: odd requires total ones odd, even requires total ones even.
  - **STOP:** `STOP_BITS` bit periods; sample at each terminal count. Any stop sample of 0 sets `f_err`. At the final stop sample, commit the frame and go to IDLE.
- **Armed flag:**
  - Cleared on commit of a frame with `f_err` = 1.
  - Set when `rx_s` = 1 is seen in IDLE.
  - Effect: a line held low (break) produces exactly one framing-error frame, not a stream of them.
- **Commit rules, evaluated on the commit cycle:**
  - **`valid` = 0, or `valid` & `ready`:** load `data_out`, `parity_err` and `frame_err`; set `valid` = 1; clear `overrun`. The simultaneous-accept case loads the new frame with no overrun.
  - **`valid` = 1 and `ready` = 0:** discard the new frame; `data_out` and the error flags are unchanged; set `overrun` = 1.
- **Handshake without commit:** `valid` & `ready` clears `valid` and `overrun` on the next edge. `data_out` retains its value.
- **Reset values:**
  - Outputs: `valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun` = 0, `data_out` = 0.
  - Internal: FSM = IDLE, armed = 1, counters = 0, synchroniser = 1.
- **Reset mid-frame:** the partial frame is abandoned with no commit. Afterwards, a new start needs a fresh `rx_s` falling level.

## Timing
- `rx` → `rx_s` latency is 2 cycles.
- **Sample instants:** with IDLE exit at cycle T0 (START entered), bit k of the frame (k = 0 is the first data bit) is sampled at T0 + `CLOCKS_PER_PULSE/2` + (k+1)·`CLOCKS_PER_PULSE`, give or take 1 cycle.
- `valid` rises on the clock edge that takes the final stop sample, so outputs are visible the cycle after that sample.
- Error flags change only together with a commit; they never change while `valid` is held.
- **Throughput:** back-to-back frames are supported. The FSM is in IDLE ≥ `CLOCKS_PER_PULSE/2` cycles before the next start edge arrives.
- `ready` may be held high permanently; each frame then produces a 1-cycle `valid` pulse.

## Test plan
- **Nominal 8N1:** `CLOCKS_PER_PULSE` = 16, 8N1, send 0xA5 with `ready` = 1 → one `valid` pulse, `data_out` = 0xA5, all flags 0.
- **Even parity:** `PARITY` = 2. Send 0x3C with parity bit 0 → no errors. Send 0x3C with parity bit 1 → `parity_err` = 1, `data_out` = 0x3C.
- **Framing and break:** stop bit forced to 0 on 0x55 → `frame_err` = 1. Then hold `rx` low for 40 bit periods → exactly one further frame, with `data_out` = 0x00 and `frame_err` = 1, until `rx` returns high.
- **Glitch rejection:** drive a 5-cycle low pulse on `rx` (less than 8 cycles, i.e. `CLOCKS_PER_PULSE/2`) → no `valid`; the following 0x12 is received correctly.
- **Overrun:** `ready` = 0, send 0x11 then 0x22 → `data_out` = 0x11, `overrun` = 1. Raise `ready` for 1 cycle → `valid` = 0 and `overrun` = 0. Also check the simultaneous case: `ready` pulsed on the commit cycle of 0x22 → `data_out` = 0x22, `overrun` = 0.
- **Config and reset:** `DATA_BITS` = 7, `PARITY` = 1, `STOP_BITS` = 2, send 0x5A → `data_out` = 7'h5A, no errors. Assert `rst` mid-data-bit → all outputs return to reset values immediately; the next frame, 0x33, is received correctly.
